// File: rtl/rx_serial_param.sv
// ---------------------------------------------------------------------------
// rx_serial_param
//
// Parametrised asynchronous serial receiver. Oversamples the RX line with a
// per-bit tick counter, checks a configurable parity bit and one or two stop
// bits, and presents each received word on a valid/ready interface with
// per-frame parity/framing flags and overrun detection.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   DATA_BITS     data bits per frame (1..16), LSB first on the line
//   PARITY_MODE   0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits checked (1 or 2)
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   rxd            serial line, idle high, asynchronous to clock
//   data_ready     consumer accepts data this cycle
//   data           last received word
//   data_valid     data holds an unconsumed frame
//   parity_error   parity mismatch in the held frame
//   framing_error  a stop bit sampled low in the held frame
//   overrun        a frame was overwritten before consumption
//   busy           frame reception in progress
// ---------------------------------------------------------------------------
module rx_serial_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 7,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF    = CLKS_PER_BIT / 2;
    localparam int TICK_W  = $clog2(CLKS_PER_BIT);
    localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF  = TICK_W'(HALF - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PARITY = 1'(PARITY_MODE != 0);
    localparam logic              ODD_PARITY = 1'(PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Line synchroniser; resets to the idle level so reset never looks
    // like a start edge.
    logic sync1, rxd_s;

    // Bit timing
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tick_last, tick_half;
    logic              state_change;

    // Frame under reception
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_f;
    logic                 frm_err_f;

    // Decoded controls
    logic bit_tick;
    logic frame_done;
    logic consume;

    // -----------------------------------------------------------------------
    // Input synchroniser
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    assign tick_last    = (tick == TICK_LAST);
    assign tick_half    = (tick == TICK_HALF);
    assign state_change = (state_next != state);
    assign consume      = data_valid & data_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // Mid-point of the start bit: a line already back high was a
                // glitch, so drop it without touching the outputs.
                if (tick_half) begin
                    state_next = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_last && (bit_cnt == DATA_LAST)) begin
                    state_next = HAS_PARITY ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick_last) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at the mid-point of the last stop bit lets a start
                // edge half a bit later be caught by IDLE.
                if (tick_last && (bit_cnt == STOP_LAST)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy       = 1'b1;
        bit_tick   = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_DATA, S_PARITY, S_STOP: begin
                bit_tick = tick_last;
            end
            S_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit timing and frame capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_f <= 1'b0;
            frm_err_f <= 1'b0;
        end else begin
            // Tick restarts on every state entry so each state measures its
            // own sample points from the edge it was entered on.
            if (state_change || (state == S_IDLE) || tick_last) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end

            if (state_change) begin
                bit_cnt <= '0;
            end else if (bit_tick) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state == S_IDLE) begin
                par_err_f <= 1'b0;
                frm_err_f <= 1'b0;
            end

            if ((state == S_DATA) && bit_tick) begin
                shreg[bit_cnt] <= rxd_s;
            end

            // Even: data and parity bit must XOR to 0; odd: to 1.
            if ((state == S_PARITY) && bit_tick) begin
                par_err_f <= (^shreg ^ rxd_s) ^ ODD_PARITY;
            end

            if ((state == S_STOP) && bit_tick && !rxd_s) begin
                frm_err_f <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer and valid/ready handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data          <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (frame_done) begin
            // A new frame always loads. If the held one is consumed on this
            // same edge nothing was lost; otherwise it is an overrun, and an
            // earlier overrun stays flagged.
            data          <= shreg;
            parity_error  <= par_err_f;
            framing_error <= frm_err_f;
            data_valid    <= 1'b1;
            overrun       <= data_valid & ~data_ready;
        end else if (consume) begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_serial_param.sv
module tb_rx_serial_param;

    logic clock = 1'b0;
    logic reset;
    logic rxd;
    logic ready_level;
    logic data_ready;

    // Default instance: 16 clocks/bit, 7 data bits, even parity, 2 stops
    logic [6:0] data;
    logic       data_valid, parity_error, framing_error, overrun, busy;
    // Odd parity instance
    logic [6:0] data_o;
    logic       data_valid_o, parity_error_o, framing_error_o, overrun_o, busy_o;
    // Single stop bit instance
    logic [6:0] data_s;
    logic       data_valid_s, parity_error_s, framing_error_s, overrun_s, busy_s;

    int cyc       = 0;
    int pulse_cyc = -1;
    int fall_cyc  = 0;
    int rise_cyc  = -1;
    int errors    = 0;
    int checks    = 0;
    logic dv_q    = 1'b0;
    logic [6:0] log_q[$];

    rx_serial_param u_dut (
        .clock         (clock),
        .reset         (reset),
        .rxd           (rxd),
        .data_ready    (data_ready),
        .data          (data),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    rx_serial_param #(.PARITY_MODE(2)) u_odd (
        .clock         (clock),
        .reset         (reset),
        .rxd           (rxd),
        .data_ready    (data_ready),
        .data          (data_o),
        .data_valid    (data_valid_o),
        .parity_error  (parity_error_o),
        .framing_error (framing_error_o),
        .overrun       (overrun_o),
        .busy          (busy_o)
    );

    rx_serial_param #(.STOP_BITS(1)) u_stop1 (
        .clock         (clock),
        .reset         (reset),
        .rxd           (rxd),
        .data_ready    (data_ready),
        .data          (data_s),
        .data_valid    (data_valid_s),
        .parity_error  (parity_error_s),
        .framing_error (framing_error_s),
        .overrun       (overrun_s),
        .busy          (busy_s)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // data_ready is a steady level plus an optional single-cycle pulse
    assign data_ready = ready_level | (cyc == pulse_cyc);

    // Cycle on which data_valid of the default instance rises
    always @(negedge clock) begin
        if (data_valid && !dv_q) rise_cyc = cyc;
        dv_q = data_valid;
    end

    // Words consumed by the handshake (pre-edge values)
    always @(posedge clock) begin
        if (data_valid && data_ready) log_q.push_back(data);
    end

    // Drive one frame from a negedge: start, 7 data LSB first, parity, two
    // stop bits, 16 cycles each. limit > 0 stops after that many cycles.
    task automatic send_frame(input logic [6:0] d, input logic par,
                              input logic s1, input logic s2, input int limit);
        logic [10:0] bits;
        int n;
        bits = {s2, s1, par, d, 1'b0};
        fall_cyc = cyc;
        n = 0;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < 16; c++) begin
                rxd = bits[i];
                @(negedge clock);
                n++;
                if (n == limit) return;
            end
        end
        rxd = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rxd = 1'b1;
        ready_level = 1'b0;
        pulse_cyc = -1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        log_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (data !== 7'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        checks++; if ({parity_error, framing_error, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {parity_error, framing_error, overrun}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({data_valid_o, data_valid_s, busy_o, busy_s} !== 4'b0000) begin errors++; $display("FAIL reset_variants got=%b exp=0000", {data_valid_o, data_valid_s, busy_o, busy_s}); end
    endtask

    // 0x35 has four ones: even parity bit 0
    task automatic test_clean();
        do_reset();
        rise_cyc = -1;
        send_frame(7'h35, 1'b0, 1'b1, 1'b1, 0);
        checks++; if (data !== 7'h35) begin errors++; $display("FAIL clean_data got=%h exp=35", data); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL clean_valid got=%b exp=1", data_valid); end
        // 3 cycles sync + idle detect, then 8 + 16*10 + 1
        checks++; if (rise_cyc - fall_cyc !== 172) begin errors++; $display("FAIL clean_latency got=%0d exp=172", rise_cyc - fall_cyc); end
        checks++; if ({parity_error, framing_error, overrun} !== 3'b000) begin errors++; $display("FAIL clean_flags got=%b exp=000", {parity_error, framing_error, overrun}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy got=%b exp=0", busy); end
        checks++; if ({data_o, parity_error_o, framing_error_o, busy_o} !== {7'h35, 3'b100}) begin errors++; $display("FAIL clean_odd got=%h/%b exp=35/100", data_o, {parity_error_o, framing_error_o, busy_o}); end
        checks++; if ({data_s, data_valid_s, parity_error_s, overrun_s, busy_s} !== {7'h35, 4'b1000}) begin errors++; $display("FAIL clean_stop1 got=%h/%b exp=35/1000", data_s, {data_valid_s, parity_error_s, overrun_s, busy_s}); end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(7'h35, 1'b1, 1'b1, 1'b1, 0);
        checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL parity_even_err got=%b exp=1", parity_error); end
        checks++; if (data !== 7'h35) begin errors++; $display("FAIL parity_even_data got=%h exp=35", data); end
        checks++; if (parity_error_o !== 1'b0) begin errors++; $display("FAIL parity_odd_err got=%b exp=0", parity_error_o); end
        checks++; if ({data_o, data_valid_o, overrun_o} !== {7'h35, 2'b10}) begin errors++; $display("FAIL parity_odd_data got=%h/%b exp=35/10", data_o, {data_valid_o, overrun_o}); end
    endtask

    task automatic test_framing();
        do_reset();
        send_frame(7'h35, 1'b0, 1'b1, 1'b0, 0);
        checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_err got=%b exp=1", framing_error); end
        checks++; if ({data, data_valid, parity_error} !== {7'h35, 2'b10}) begin errors++; $display("FAIL framing_data got=%h/%b exp=35/10", data, {data_valid, parity_error}); end
        checks++; if ({data_s, framing_error_s} !== {7'h35, 1'b0}) begin errors++; $display("FAIL framing_stop1 got=%h/%b exp=35/0", data_s, framing_error_s); end
    endtask

    task automatic test_glitch();
        do_reset();
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        repeat (20) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", data_valid); end
        // 0x12 has two ones: parity bit 0
        send_frame(7'h12, 1'b0, 1'b1, 1'b1, 0);
        checks++; if ({data, data_valid, parity_error, framing_error} !== {7'h12, 3'b100}) begin errors++; $display("FAIL glitch_next got=%h/%b exp=12/100", data, {data_valid, parity_error, framing_error}); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(7'h11, 1'b0, 1'b1, 1'b1, 0);
        send_frame(7'h22, 1'b0, 1'b1, 1'b1, 0);
        checks++; if (data !== 7'h22) begin errors++; $display("FAIL ovr_data got=%h exp=22", data); end
        checks++; if ({data_valid, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_flag got=%b exp=11", {data_valid, overrun}); end
        ready_level = 1'b1;
        @(negedge clock);
        ready_level = 1'b0;
        @(negedge clock);
        checks++; if ({data_valid, overrun} !== 2'b00) begin errors++; $display("FAIL ovr_consume got=%b exp=00", {data_valid, overrun}); end
        checks++; if (data !== 7'h22) begin errors++; $display("FAIL ovr_keep got=%h exp=22", data); end
        ready_level = 1'b1;
        repeat (3) @(negedge clock);
        ready_level = 1'b0;
        checks++; if ({data, data_valid} !== {7'h22, 1'b0}) begin errors++; $display("FAIL ovr_idle_ready got=%h/%b exp=22/0", data, data_valid); end

        log_q.delete();
        send_frame(7'h11, 1'b0, 1'b1, 1'b1, 0);
        checks++; if ({data, data_valid, overrun} !== {7'h11, 2'b10}) begin errors++; $display("FAIL ovr_first got=%h/%b exp=11/10", data, {data_valid, overrun}); end
        // Ready pulse lands on the DONE cycle of the second frame
        pulse_cyc = cyc + 171;
        send_frame(7'h22, 1'b0, 1'b1, 1'b1, 0);
        pulse_cyc = -1;
        checks++; if ({data, data_valid, overrun} !== {7'h22, 2'b10}) begin errors++; $display("FAIL ovr_simul got=%h/%b exp=22/10", data, {data_valid, overrun}); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL ovr_simul_count got=%0d exp=1", log_q.size()); end
        if (log_q.size() >= 1) begin
            checks++; if (log_q[0] !== 7'h11) begin errors++; $display("FAIL ovr_simul_word got=%h exp=11", log_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(7'h35, 1'b0, 1'b1, 1'b1, 0);
        checks++; if ({data, data_valid} !== {7'h35, 1'b1}) begin errors++; $display("FAIL mid_pre got=%h/%b exp=35/1", data, data_valid); end
        // 72 cycles in: middle of data bit 3
        send_frame(7'h55, 1'b0, 1'b1, 1'b1, 72);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if ({data, data_valid} !== {7'h00, 1'b0}) begin errors++; $display("FAIL mid_reset_data got=%h/%b exp=00/0", data, data_valid); end
        checks++; if ({parity_error, framing_error, overrun, busy} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags got=%b exp=0000", {parity_error, framing_error, overrun, busy}); end
        @(negedge clock);
        rxd = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        // 0x7F has seven ones: parity bit 1
        send_frame(7'h7F, 1'b1, 1'b1, 1'b1, 0);
        checks++; if ({data, data_valid, parity_error, framing_error} !== {7'h7F, 3'b100}) begin errors++; $display("FAIL mid_after got=%h/%b exp=7f/100", data, {data_valid, parity_error, framing_error}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_level = 1'b1;
        // 0x2A: three ones -> parity 1; 0x55: four ones -> parity 0
        send_frame(7'h2A, 1'b1, 1'b1, 1'b1, 0);
        send_frame(7'h55, 1'b0, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clock);
        ready_level = 1'b0;
        checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", log_q.size()); end
        if (log_q.size() >= 2) begin
            checks++; if (log_q[0] !== 7'h2A) begin errors++; $display("FAIL b2b_first got=%h exp=2a", log_q[0]); end
            checks++; if (log_q[1] !== 7'h55) begin errors++; $display("FAIL b2b_second got=%h exp=55", log_q[1]); end
        end
        checks++; if ({data_valid, overrun, parity_error, framing_error} !== 4'b0000) begin errors++; $display("FAIL b2b_final got=%b exp=0000", {data_valid, overrun, parity_error, framing_error}); end
    endtask

    initial begin
        reset = 1'b1;
        rxd = 1'b1;
        ready_level = 1'b0;
        test_reset();
        test_clean();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_serial_param.md
Name: rx_serial_param

Overview:
Parametrised asynchronous serial receiver: configurable data width, parity mode, stop-bit count and oversampling divisor. Integrates control, datapath and output buffering, replacing the fixed-format receive control unit with separate datapath.
Adds start-bit glitch rejection, per-frame parity and framing error flags, and a valid/ready output handshake with overrun detection. Sits between the board RX pin and the consumer logic.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=4); HALF = floor(CLKS_PER_BIT/2)
DATA_BITS, 7, data bits per frame (1..16), LSB first
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 2, stop bits checked (1 or 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
rxd  in  1  serial line, idle high, asynchronous to clock
data_ready  in  1  consumer accepts data this cycle
data  out  DATA_BITS  last received word
data_valid  out  1  data holds an unconsumed frame
parity_error  out  1  parity mismatch in the held frame (0 if PARITY_MODE=0)
framing_error  out  1  a stop bit sampled low in the held frame
overrun  out  1  a frame was overwritten before consumption
busy  out  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (async, active-high): state IDLE; sync flops = 1; bit counter and tick counter = 0; data = 0; data_valid, parity_error, framing_error, overrun, busy = 0.
- rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s only.
- Tick counter counts 0..CLKS_PER_BIT-1. Cleared on every state entry.
- IDLE: when rxd_s = 0 -> START (t = 0 is the edge leaving IDLE).
- START: after HALF cycles, sample rxd_s. If 0 -> DATA. If 1 -> IDLE, glitch rejected, no output change.
- DATA: sample rxd_s every CLKS_PER_BIT cycles into a shift register, LSB first. After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: one sample after CLKS_PER_BIT cycles.
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if XOR(data, parity bit) = 0.
  - Then -> STOP.
- STOP: STOP_BITS samples, spaced CLKS_PER_BIT. Any 0 sample sets the frame's framing flag. After the last sample -> DONE.
- DONE: one cycle. Loads data, parity_error, framing_error from the frame, sets data_valid = 1, -> IDLE. Errored frames are still delivered.
- data_valid rises at edge t + HALF + CLKS_PER_BIT*(DATA_BITS + P + STOP_BITS) + 1, where P = (PARITY_MODE != 0).
- Reception ends at the mid-point of the last stop bit, so a start edge arriving half a bit later is detected.
- Handshake: a frame is consumed on any cycle with data_valid & data_ready.
  - On consumption: data_valid, overrun, parity_error, framing_error clear on the next edge. data keeps its value.
- Overrun: DONE while data_valid = 1 and no consumption that cycle -> new frame overwrites data and flags, data_valid stays 1, overrun = 1.
  - overrun stays set until the next consumption.
- Simultaneous DONE and consumption: the new frame loads, data_valid stays 1, overrun = 0.
- data_ready while data_valid = 0 has no effect.
- rxd changes mid-bit are ignored. Only the scheduled samples count; no majority vote.
- Reset mid-frame: the frame is discarded, outputs return to reset values immediately.
- busy = 1 in START, DATA, PARITY, STOP and DONE.
- Unused states -> IDLE.

Test Plan:
1. Clean frame (defaults): data 0x35, even parity bit 0, two stop bits of 1 -> data = 0x35, data_valid = 1 at the computed cycle (t + 8 + 16*10 + 1 = t + 169), both error flags 0, busy back to 0.
2. Same frame with parity bit 1 -> parity_error = 1, data = 0x35.
   - Repeat with PARITY_MODE = 2 and parity bit 1 -> parity_error = 0.
3. Second stop bit driven 0 -> framing_error = 1, data still delivered.
   - With STOP_BITS = 1 the same stimulus gives framing_error = 0.
4. rxd low for 4 cycles only, then high -> START aborts, busy returns to 0, data_valid stays 0.
   - A following valid frame 0x12 is received correctly.
5. Send 0x11 then 0x22 with data_ready = 0 -> data = 0x22, overrun = 1.
   - Pulse data_ready -> data_valid = 0, overrun = 0.
   - Repeat with data_ready asserted in the DONE cycle -> overrun stays 0.
6. Assert reset during DATA bit 3 -> all outputs 0, busy = 0 immediately.
   - After release, frame 0x7F is received cleanly.
   - Back-to-back frames with start edges 8 cycles after the stop mid-point are both received.
